// File: rtl/keypad_pkg.sv
// Shared types and constants for the Pmod KYPD column scanner.
package keypad_pkg;

  // Column FSM: DRIVE holds a column low, SAMPLE captures its rows.
  typedef enum logic {
    DRIVE  = 1'b0,
    SAMPLE = 1'b1
  } scan_state_e;

  // Classification of a complete 16-key frame.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_class_e;

  // Hex code of each key, indexed by {col[1:0], row[1:0]}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the key-event output bundle.
//
// Event semantics: key_valid is a one-cycle strobe with no ready/back-pressure;
// key_code is valid in the strobe cycle and stays stable until the next strobe.
// key_held is a level that is high while the accepted key remains pressed.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [3:0]  col_n;      // column drive, active low, one-hot-low
  logic [3:0]  row_n;      // raw row sense, active low, asynchronous
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  scan_state_e scan_state; // debug view of the column FSM

  modport master (
    output col_n, key_code, key_valid, key_held, scan_state,
    input  row_n
  );

  modport slave (
    input  col_n, key_code, key_valid, key_held, scan_state,
    output row_n
  );

endinterface

// File: rtl/keypad_scanner_frame_debounce.sv
// Frame-level debouncer: turns a stream of classified frames into key events.
module frame_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_end_i,
  input  frame_class_e class_i,
  input  logic [3:0]   cand_i,
  output logic [3:0]   key_code_o,
  output logic         key_valid_o,
  output logic         key_held_o
);

  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS);

  frame_class_e prev_class_q, prev_class_d;
  logic [3:0]   prev_cand_q,  prev_cand_d;
  logic [3:0]   stable_q,     stable_d;
  logic [3:0]   key_code_q,   key_code_d;
  logic         key_held_q,   key_held_d;
  logic         key_valid_q,  key_valid_d;
  logic         same_frame;

  // Register all debounce state; reset looks like a history of EMPTY frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_class_q <= EMPTY;
      prev_cand_q  <= 4'h0;
      stable_q     <= 4'd0;
      key_code_q   <= 4'h0;
      key_held_q   <= 1'b0;
      key_valid_q  <= 1'b0;
    end else begin
      prev_class_q <= prev_class_d;
      prev_cand_q  <= prev_cand_d;
      stable_q     <= stable_d;
      key_code_q   <= key_code_d;
      key_held_q   <= key_held_d;
      key_valid_q  <= key_valid_d;
    end
  end

  // Stability counting and accept/release decision at each frame end.
  always_comb begin
    prev_class_d = prev_class_q;
    prev_cand_d  = prev_cand_q;
    stable_d     = stable_q;
    key_code_d   = key_code_q;
    key_held_d   = key_held_q;
    key_valid_d  = 1'b0;
    same_frame   = (class_i == prev_class_q) && (cand_i == prev_cand_q);

    if (frame_end_i) begin
      prev_class_d = class_i;
      prev_cand_d  = cand_i;
      if (!same_frame) begin
        stable_d = 4'd1;
      end else if (stable_q < STABLE_MAX) begin
        stable_d = stable_q + 4'd1;
      end

      if (stable_d == STABLE_MAX) begin
        if (class_i == SINGLE) begin
          // A held key never re-fires; a different key fires even without release.
          if (!key_held_q || (cand_i != key_code_q)) begin
            key_code_d  = cand_i;
            key_held_d  = 1'b1;
            key_valid_d = 1'b1;
          end
        end else begin
          // Ghosted frames count as released; last code is kept for display.
          key_held_d = 1'b0;
        end
      end
    end
  end

  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scan driver for the 4x4 keypad: synchronizer, column FSM, frame
// capture and classification, feeding the frame debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(SCAN_DIV - 2);

  logic [3:0]       row_meta_q, row_sync_q;
  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [15:0]      frame_q, frame_d;

  logic [15:0]      frame_full;
  logic [4:0]       low_cnt;
  logic [3:0]       low_idx;
  frame_class_e     frame_class;
  logic [3:0]       cand;
  logic             frame_end;

  // Two-flop synchronizer on the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= bus.row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Column FSM state and scan datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DRIVE;
      cnt_q     <= '0;
      col_idx_q <= 2'd0;
      frame_q   <= 16'hFFFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_idx_q <= col_idx_d;
      frame_q   <= frame_d;
    end
  end

  // Next state: count through the column period, sample on its last cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_idx_d = col_idx_q;
    frame_d   = frame_q;
    case (state_q)
      DRIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_PRE) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        frame_d[{col_idx_q, 2'b00} +: 4] = row_sync_q;
        col_idx_d = col_idx_q + 2'd1;
        cnt_d     = '0;
        state_d   = DRIVE;
      end
      default: state_d = DRIVE;
    endcase
  end

  // Column drive is decoded straight from the column index register.
  always_comb begin
    bus.col_n      = ~(4'b0001 << col_idx_q);
    bus.scan_state = state_q;
  end

  // Classify the frame including the column being sampled this cycle.
  always_comb begin
    frame_full        = frame_q;
    frame_full[15:12] = row_sync_q;
    low_cnt           = 5'd0;
    low_idx           = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!frame_full[i]) begin
        low_cnt = low_cnt + 5'd1;
        low_idx = 4'(i);
      end
    end
    frame_class = EMPTY;
    cand        = 4'h0;
    if (low_cnt == 5'd1) begin
      frame_class = SINGLE;
      cand        = KEY_MAP[low_idx];
    end else if (low_cnt > 5'd1) begin
      frame_class = MULTI;
    end
  end

  assign frame_end = (state_q == SAMPLE) && (col_idx_q == 2'd3);

  frame_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_frame_debounce (
    .clk         (clk),
    .rst         (rst),
    .frame_end_i (frame_end),
    .class_i     (frame_class),
    .cand_i      (cand),
    .key_code_o  (bus.key_code),
    .key_valid_o (bus.key_valid),
    .key_held_o  (bus.key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad and a
// frame-history reference model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- keypad model ----------------
  logic [15:0] pressed = 16'h0000; // bit v set = key with hex value v held down

  // Physical layout: position col*4+row -> printed key legend.
  function automatic logic [3:0] legend(input int p);
    case (p)
      0: legend = 4'h1;  1: legend = 4'h4;  2: legend = 4'h7;  3: legend = 4'h0;
      4: legend = 4'h2;  5: legend = 4'h5;  6: legend = 4'h8;  7: legend = 4'hF;
      8: legend = 4'h3;  9: legend = 4'h6; 10: legend = 4'h9; 11: legend = 4'hE;
      12: legend = 4'hA; 13: legend = 4'hB; 14: legend = 4'hC; default: legend = 4'hD;
    endcase
  endfunction

  always_comb begin
    kif.row_n = 4'hF;
    for (int p = 0; p < 16; p++) begin
      if (kif.col_n[p / 4] === 1'b0 && pressed[legend(p)]) kif.row_n[p % 4] = 1'b0;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  bit checking = 1'b0;

  logic [3:0] exp_q [$];   // codes of pulses the model expects, in order
  int         hist [$];    // last DEB frame observations: -1 empty, -2 multi, else key
  logic [3:0] exp_code;
  logic       exp_held;
  int         pulse_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_code  = 4'h0;
    exp_held  = 1'b0;
    pulse_cyc = -1;
  endtask

  // Called at the first cycle after a frame with key set m has completed.
  task automatic model_frame(input logic [15:0] m);
    int  obs;
    bit  all_same;
    obs = -1;
    if ($countones(m) == 1) begin
      for (int v = 0; v < 16; v++) if (m[v]) obs = v;
    end else if ($countones(m) > 1) begin
      obs = -2;
    end
    hist.push_back(obs);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_same = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != obs) all_same = 1'b0;
    if (all_same) begin
      if (obs >= 0) begin
        if (!exp_held || exp_code != 4'(obs)) begin
          exp_code  = 4'(obs);
          exp_held  = 1'b1;
          pulse_cyc = cyc;
          exp_q.push_back(4'(obs));
        end
      end else begin
        exp_held = 1'b0;
      end
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [3:0] exp_col;
    if (checking) begin
      exp_col = ~(4'b0001 << ((cyc / 4) % 4));
      check_val("col_n", kif.col_n, exp_col);
      check_val("scan_state", kif.scan_state, (cyc % 4 == 3) ? 1 : 0);
      check_val("key_valid", kif.key_valid, (cyc == pulse_cyc) ? 1 : 0);
      check_val("key_held", kif.key_held, exp_held);
      check_val("key_code", kif.key_code, exp_code);
      if (kif.key_valid === 1'b1) begin
        pulse_cnt++;
        check_val("pulse_expected", (exp_q.size() != 0) ? 1 : 0, 1);
        if (exp_q.size() != 0) check_val("pulse_code", kif.key_code, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Must be entered just after a frame-boundary clock edge.
  task automatic run_frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      pressed = m;
      repeat (FRAME) @(posedge clk);
      #1;
      model_frame(m);
    end
  endtask

  task automatic key(input int v, output logic [15:0] m);
    m = 16'h0000;
    m[v] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] m, m2;
    int p0, a, b;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;

    // Idle scan: column rotation and quiet outputs.
    run_frames(16'h0000, 2);

    // Clean hold of key 5: exactly one pulse.
    p0 = pulse_cnt;
    key(5, m);
    run_frames(m, 4);
    run_frames(16'h0000, 2);
    check_val("hold5_pulses", pulse_cnt - p0, 1);

    // One-frame tap of key 9 is rejected.
    p0 = pulse_cnt;
    key(9, m);
    run_frames(m, 1);
    run_frames(16'h0000, 3);
    check_val("tap9_pulses", pulse_cnt - p0, 0);

    // Keys 1 and 2 together: ghost-rejected.
    p0 = pulse_cnt;
    m = 16'h0000; m[1] = 1'b1; m[2] = 1'b1;
    run_frames(m, 4);
    check_val("multi_held", kif.key_held, 0);
    run_frames(16'h0000, 2);
    check_val("multi_pulses", pulse_cnt - p0, 0);

    // 5 then directly D, release, re-press D.
    p0 = pulse_cnt;
    key(5, m);
    key(13, m2);
    run_frames(m, 3);
    run_frames(m2, 3);
    check_val("switch_code", kif.key_code, 4'hD);
    run_frames(16'h0000, 2);
    check_val("release_held", kif.key_held, 0);
    run_frames(m2, 3);
    run_frames(16'h0000, 2);
    check_val("switch_pulses", pulse_cnt - p0, 3);

    // Reset in the middle of a hold of key 5.
    p0 = pulse_cnt;
    run_frames(m, 3);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_frames(m, 4);
    run_frames(16'h0000, 2);
    check_val("reset_pulses", pulse_cnt - p0, 2);

    // Randomized key sequences.
    for (int s = 0; s < 24; s++) begin
      m = 16'h0000;
      case ($urandom_range(0, 3))
        0: m = 16'h0000;
        1, 2: m[$urandom_range(0, 15)] = 1'b1;
        default: begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          m[a] = 1'b1;
          m[b] = 1'b1;
        end
      endcase
      run_frames(m, $urandom_range(1, 3));
    end
    run_frames(16'h0000, 2);

    check_val("exp_q_drained", exp_q.size(), 0);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
